instr_fetch: RTL

Instruction fetch stage of the RV32I single-cycle core, directly upstream of `control_decoder`. Owns the program counter and issues one request at a time to instruction memory. Buffers the returned word and holds it until the core consumes it. Breaks the opcode into the one-hot class strobes and the `fun3`/`fun7` fields that `control_decoder` expects, and handles PC redirects from branch, jal and jalr resolution.

---
 rtl/rv32i_pkg.sv | 23 ++
 rtl/instr_fetch_if.sv | 10 +
 rtl/opcode_decode.sv | 59 +++++
 rtl/instr_fetch.sv | 138 +++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcode classes, fetch FSM states, canonical NOP.
package rv32i_pkg;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response bus between fetch (master) and imem (slave).
interface instr_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (output imem_req, output imem_addr, input imem_rvalid, input imem_rdata);
   modport slave  (input imem_req, input imem_addr, output imem_rvalid, output imem_rdata);
endinterface

// File: rtl/opcode_decode.sv
// Combinational opcode classifier feeding control_decoder; all outputs forced low when not valid.
module opcode_decode
   import rv32i_pkg::*;
(
   input  logic [31:0] instr,
   input  logic        valid,
   output logic        r_type,
   output logic        i_type,
   output logic        load,
   output logic        store,
   output logic        branch,
   output logic        jal,
   output logic        jalr,
   output logic        lui,
   output logic        auipc,
   output logic        illegal,
   output logic [2:0]  fun3,
   output logic        fun7
);

   // Only opcode, funct3 and bit 30 matter for classification.
   logic unused_fields;
   assign unused_fields = ^{instr[31], instr[29:15], instr[11:7]};

   // One-hot class strobes plus the shift/sub qualifier bit.
   always_comb begin
      r_type  = 1'b0;
      i_type  = 1'b0;
      load    = 1'b0;
      store   = 1'b0;
      branch  = 1'b0;
      jal     = 1'b0;
      jalr    = 1'b0;
      lui     = 1'b0;
      auipc   = 1'b0;
      illegal = 1'b0;
      fun3    = 3'b000;
      fun7    = 1'b0;
      if (valid) begin
         fun3 = instr[14:12];
         case (instr[6:0])
            OP_RTYPE:  r_type  = 1'b1;
            OP_ITYPE:  i_type  = 1'b1;
            OP_LOAD:   load    = 1'b1;
            OP_STORE:  store   = 1'b1;
            OP_BRANCH: branch  = 1'b1;
            OP_JAL:    jal     = 1'b1;
            OP_JALR:   jalr    = 1'b1;
            OP_LUI:    lui     = 1'b1;
            OP_AUIPC:  auipc   = 1'b1;
            default:   illegal = 1'b1;
         endcase
         // bit 30 only distinguishes sub/sra in R-type and srai in I-type
         fun7 = instr[30] & ((instr[6:0] == OP_RTYPE) ||
                             ((instr[6:0] == OP_ITYPE) && (instr[14:12] == 3'b101)));
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, single-outstanding imem request, instruction buffer, redirect handling.
//
// state | meaning
// BOOT  | after reset; load RESET_PC, clear kill
// FETCH | request pulse to imem at fetch_pc
// WAIT  | waiting for imem_rvalid; kill drops a response made stale by a redirect
// HOLD  | instruction buffered and presented until consumed or redirected
module instr_fetch
   import rv32i_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
   input  logic              clk,
   input  logic              rst,
   instr_fetch_if.master     bus,
   input  logic              redirect,
   input  logic [31:0]       redirect_pc,
   input  logic              stall,
   output logic              instr_valid,
   output logic [31:0]       instr,
   output logic [31:0]       pc,
   output logic [31:0]       pc_plus4,
   output logic              r_type,
   output logic              i_type,
   output logic              load,
   output logic              store,
   output logic              branch,
   output logic              jal,
   output logic              jalr,
   output logic              lui,
   output logic              auipc,
   output logic              illegal,
   output logic [2:0]        fun3,
   output logic              fun7
);

   fetch_state_t state_q, state_d;
   logic [31:0]  fetch_pc_q, fetch_pc_d;
   logic         kill_q, kill_d;
   logic [31:0]  instr_q, instr_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  target;

   assign target = {redirect_pc[31:2], 2'b00};

   // Next-state and register-update decisions.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      kill_d     = kill_q;
      instr_d    = instr_q;
      pc_d       = pc_q;
      unique case (state_q)
         BOOT: begin
            fetch_pc_d = RESET_PC;
            kill_d     = 1'b0;
            state_d    = FETCH;
         end
         FETCH: begin
            state_d = WAIT;
            if (redirect) begin
               fetch_pc_d = target;
               kill_d     = 1'b1;
            end
         end
         WAIT: begin
            if (bus.imem_rvalid) begin
               kill_d = 1'b0;
               if (redirect) begin
                  fetch_pc_d = target;
                  state_d    = FETCH;
               end else if (kill_q) begin
                  state_d = FETCH;
               end else begin
                  instr_d = bus.imem_rdata;
                  pc_d    = fetch_pc_q;
                  state_d = HOLD;
               end
            end else if (redirect) begin
               fetch_pc_d = target;
               kill_d     = 1'b1;
            end
         end
         HOLD: begin
            if (redirect) begin
               fetch_pc_d = target;
               state_d    = FETCH;
            end else if (!stall) begin
               fetch_pc_d = pc_q + 32'd4;
               state_d    = FETCH;
            end
         end
         default: state_d = BOOT;
      endcase
   end

   // State, PC and instruction buffer registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= BOOT;
         fetch_pc_q <= RESET_PC;
         kill_q     <= 1'b0;
         instr_q    <= NOP_INSTR;
         pc_q       <= RESET_PC;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         kill_q     <= kill_d;
         instr_q    <= instr_d;
         pc_q       <= pc_d;
      end
   end

   assign bus.imem_req  = (state_q == FETCH);
   assign bus.imem_addr = fetch_pc_q;
   assign instr_valid   = (state_q == HOLD);
   assign instr         = instr_q;
   assign pc            = pc_q;
   assign pc_plus4      = pc_q + 32'd4;

   opcode_decode u_decode (
      .instr   (instr_q),
      .valid   (instr_valid),
      .r_type  (r_type),
      .i_type  (i_type),
      .load    (load),
      .store   (store),
      .branch  (branch),
      .jal     (jal),
      .jalr    (jalr),
      .lui     (lui),
      .auipc   (auipc),
      .illegal (illegal),
      .fun3    (fun3),
      .fun7    (fun7)
   );

endmodule
